// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder
//   Measures an incoming PWM waveform and reports, for each complete period, the
//   high time and the rising-edge-to-rising-edge period length in clk1 cycles.
//   Samples are offered on a valid/ready stream. Overwrites of an unaccepted sample
//   and a stuck (edge-less) line are flagged.
//
// Ports
//   clk1       in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   pwm_in     in   asynchronous PWM input
//   s_valid    out  sample available
//   s_ready    in   consumer accepts sample when s_valid && s_ready
//   s_high     out  high time of last complete period
//   s_period   out  period of last complete period
//   overrun    out  one-cycle pulse: unaccepted sample overwritten
//   stuck      out  no rising edge for 2^CNT_W-1 cycles
//   stuck_lvl  out  synchronized line level when stuck was raised
module pwm_duty_decoder #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             pwm_in,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [CNT_W-1:0] s_high,
    output logic [CNT_W-1:0] s_period,
    output logic             overrun,
    output logic             stuck,
    output logic             stuck_lvl
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 prev_q;
    logic [CNT_W-1:0]     hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]     per_cnt_q, per_cnt_d;
    logic                 s_valid_q;
    logic [CNT_W-1:0]     s_high_q, s_period_q;
    logic                 overrun_q, stuck_q, stuck_lvl_q;

    logic sync, rise, fall, cnt_full;
    logic start, capture, timeout;

    assign sync     = sync_q[SYNC_STAGES-1];
    assign rise     = sync & ~prev_q;
    assign fall     = ~sync & prev_q;
    assign cnt_full = (per_cnt_q == CntMax);

    // State register
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. In LOW a rise wins over the timeout so that a period of
    // exactly 2^CNT_W-1 cycles is still measured.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (rise) state_d = StHigh;
            StHigh: begin
                if (cnt_full)  state_d = StIdle;
                else if (fall) state_d = StLow;
            end
            StLow: begin
                if (rise)          state_d = StHigh;
                else if (cnt_full) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath control
    always_comb begin
        start     = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        hi_cnt_d  = hi_cnt_q;
        per_cnt_d = per_cnt_q;
        unique case (state_q)
            StIdle: start = rise;
            StHigh: timeout = cnt_full;
            StLow: begin
                capture = rise;
                timeout = cnt_full & ~rise;
            end
            default: ;
        endcase

        if (start || capture) begin
            // The edge cycle itself is the first cycle of the new period.
            hi_cnt_d  = CntOne;
            per_cnt_d = CntOne;
        end else if (timeout) begin
            hi_cnt_d  = '0;
            per_cnt_d = '0;
        end else if (state_q == StHigh) begin
            per_cnt_d = per_cnt_q + CntOne;
            if (!fall) hi_cnt_d = hi_cnt_q + CntOne;
        end else if (state_q == StLow) begin
            per_cnt_d = per_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            sync_q      <= '0;
            prev_q      <= 1'b0;
            hi_cnt_q    <= '0;
            per_cnt_q   <= '0;
            s_valid_q   <= 1'b0;
            s_high_q    <= '0;
            s_period_q  <= '0;
            overrun_q   <= 1'b0;
            stuck_q     <= 1'b0;
            stuck_lvl_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_q    <= sync;
            hi_cnt_q  <= hi_cnt_d;
            per_cnt_q <= per_cnt_d;

            // A new capture takes priority over a same-cycle handshake.
            if (capture) begin
                s_valid_q  <= 1'b1;
                s_high_q   <= hi_cnt_q;
                s_period_q <= per_cnt_q;
            end else if (s_valid_q && s_ready) begin
                s_valid_q <= 1'b0;
            end
            overrun_q <= capture & s_valid_q & ~s_ready;

            if (timeout) begin
                stuck_q     <= 1'b1;
                stuck_lvl_q <= sync;
            end else if (start) begin
                stuck_q <= 1'b0;
            end
        end
    end

    assign s_valid   = s_valid_q;
    assign s_high    = s_high_q;
    assign s_period  = s_period_q;
    assign overrun   = overrun_q;
    assign stuck     = stuck_q;
    assign stuck_lvl = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Testbench for pwm_duty_decoder: drives PWM periods, keeps a queue of expected
// samples and compares each accepted sample against it.
module tb_pwm_duty_decoder;

    localparam int unsigned CNT_W = 8;

    logic             clk1 = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic             s_ready = 1'b1;
    logic             s_valid;
    logic [CNT_W-1:0] s_high;
    logic [CNT_W-1:0] s_period;
    logic             overrun;
    logic             stuck;
    logic             stuck_lvl;

    pwm_duty_decoder #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2)
    ) dut (
        .clk1     (clk1),
        .rst      (rst),
        .pwm_in   (pwm_in),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_high   (s_high),
        .s_period (s_period),
        .overrun  (overrun),
        .stuck    (stuck),
        .stuck_lvl(stuck_lvl)
    );

    always #5 clk1 = ~clk1;

    typedef struct packed {
        logic [7:0] high;
        logic [7:0] period;
    } sample_t;

    sample_t exp_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    int      n_pops  = 0;
    int      n_ovr   = 0;
    int      n_vcyc  = 0;
    logic    have_prev = 1'b0;
    int      last_h = 0;
    int      last_p = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard consumer. An overrun means the oldest queued sample was lost.
    always @(negedge clk1) begin
        if (!rst) begin
            if (s_valid) n_vcyc++;
            if (overrun) begin
                n_ovr++;
                check_eq("ovr_depth", 32'(exp_q.size() >= 2), 1);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (s_valid && s_ready) begin
                sample_t s;
                s = '0;
                if (exp_q.size() > 0) s = exp_q.pop_front();
                check_eq("s_high", 32'(s_high), 32'(s.high));
                check_eq("s_period", 32'(s_period), 32'(s.period));
                n_pops++;
            end
        end
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic push_prev();
        sample_t s;
        if (have_prev) begin
            s.high   = 8'(last_h);
            s.period = 8'(last_p);
            exp_q.push_back(s);
        end
    endtask

    task automatic pwm_period(input int h, input int p);
        push_prev();
        pwm_in = 1'b1;
        repeat (h) step();
        pwm_in = 1'b0;
        repeat (p - h) step();
        last_h    = h;
        last_p    = p;
        have_prev = 1'b1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) step();
        exp_q.delete();
        have_prev = 1'b0;
        rst       = 1'b0;
        step();
        n_pops = 0;
        n_ovr  = 0;
        n_vcyc = 0;
    endtask

    task automatic wait_stuck(input string tag, output int cycles);
        cycles = 0;
        while (!stuck && cycles < 400) begin
            @(negedge clk1);
            cycles++;
        end
        check_eq(tag, 32'(stuck), 1);
        have_prev = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_valid"}, 32'(s_valid), 0);
        check_eq({pfx, "_high"}, 32'(s_high), 0);
        check_eq({pfx, "_period"}, 32'(s_period), 0);
        check_eq({pfx, "_overrun"}, 32'(overrun), 0);
        check_eq({pfx, "_stuck"}, 32'(stuck), 0);
        check_eq({pfx, "_stuck_lvl"}, 32'(stuck_lvl), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int duty[3];

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check_all_zero("rst");
        do_reset();

        // 1: steady H=3 P=10, first period discarded
        repeat (5) pwm_period(3, 10);
        repeat (10) step();
        check_eq("t1_samples", n_pops, 4);
        check_eq("t1_valid_cycles", n_vcyc, 4);
        check_eq("t1_sb_empty", exp_q.size(), 0);

        // 2: duty sweep, then line stuck low, then stuck high
        do_reset();
        duty = '{1, 5, 9};
        foreach (duty[i]) repeat (3) pwm_period(duty[i], 10);
        wait_stuck("t2_stuck_lo", cyc);
        check_eq("t2_stuck_lo_late", 32'(cyc >= 200), 1);
        check_eq("t2_stuck_lvl_lo", 32'(stuck_lvl), 0);
        step();
        pwm_in = 1'b1;
        repeat (10) step();
        check_eq("t2_stuck_clr", 32'(stuck), 0);
        wait_stuck("t2_stuck_hi", cyc);
        check_eq("t2_stuck_lvl_hi", 32'(stuck_lvl), 1);
        step();
        pwm_in = 1'b0;
        repeat (5) step();
        check_eq("t2_stuck_hold", 32'(stuck), 1);
        check_eq("t2_samples", n_pops, 8);
        check_eq("t2_sb_empty", exp_q.size(), 0);

        // 3: consumer stalled across three captures
        do_reset();
        s_ready = 1'b0;
        repeat (4) pwm_period(4, 8);
        repeat (3) step();
        check_eq("t3_overruns", n_ovr, 2);
        check_eq("t3_held_valid", 32'(s_valid), 1);
        check_eq("t3_held_high", 32'(s_high), 4);
        check_eq("t3_held_period", 32'(s_period), 8);
        s_ready = 1'b1;
        @(negedge clk1);
        step();
        check_eq("t3_valid_clr", 32'(s_valid), 0);
        check_eq("t3_samples", n_pops, 1);
        check_eq("t3_sb_empty", exp_q.size(), 0);

        // 4: stuck low, then recovery
        do_reset();
        repeat (2) pwm_period(3, 8);
        wait_stuck("t4_stuck", cyc);
        check_eq("t4_stuck_lvl", 32'(stuck_lvl), 0);
        repeat (40) step();
        check_eq("t4_stuck_hold", 32'(stuck), 1);
        pwm_period(2, 6);
        check_eq("t4_stuck_clr", 32'(stuck), 0);
        check_eq("t4_no_early", n_pops, 1);
        repeat (2) pwm_period(2, 6);
        repeat (4) step();
        check_eq("t4_samples", n_pops, 3);
        check_eq("t4_sb_empty", exp_q.size(), 0);

        // 5: reset in the middle of a high phase with a sample pending
        do_reset();
        s_ready = 1'b0;
        repeat (2) pwm_period(3, 9);
        check_eq("t5_pending", 32'(s_valid), 1);
        pwm_in = 1'b1;
        repeat (2) step();
        rst    = 1'b1;
        pwm_in = 1'b0;
        step();
        check_all_zero("t5");
        exp_q.delete();
        have_prev = 1'b0;
        rst       = 1'b0;
        step();
        s_ready = 1'b1;
        n_pops  = 0;
        pwm_period(4, 9);
        check_eq("t5_first_discard", n_pops, 0);
        repeat (2) pwm_period(4, 9);
        repeat (4) step();
        check_eq("t5_samples", n_pops, 2);
        check_eq("t5_sb_empty", exp_q.size(), 0);

        // 6: handshake and capture on the same edge
        do_reset();
        s_ready = 1'b0;
        pwm_period(3, 7);
        pwm_period(5, 9);
        push_prev();
        pwm_in = 1'b1;
        repeat (2) step();
        s_ready = 1'b1;
        @(negedge clk1);
        step();
        check_eq("t6_valid_kept", 32'(s_valid), 1);
        check_eq("t6_new_high", 32'(s_high), 5);
        check_eq("t6_new_period", 32'(s_period), 9);
        check_eq("t6_no_overrun", 32'(overrun), 0);
        step();
        check_eq("t6_valid_clr", 32'(s_valid), 0);
        pwm_in = 1'b0;
        repeat (4) step();
        check_eq("t6_overruns", n_ovr, 0);
        check_eq("t6_samples", n_pops, 2);
        check_eq("t6_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
